time_entry: RTL and testbench

- Front-panel writer for the countdown timer's load interface.
- The operator uses push buttons to edit a six-digit BCD HH:MM:SS value, one digit at a time with a cursor.
- Each digit is range-checked as it is edited.
- On commit, the block drives the six digit buses and a `set` pulse that the timer samples to load its count.

---
 rtl/time_entry_pkg.sv | 41 ++++
 rtl/time_entry_btn_edge.sv | 23 ++
 rtl/time_entry.sv | 121 ++++++++++++
 tb/tb_time_entry.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// Shared types and constants for the front-panel time entry block.
package time_entry_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] LIM_HO = 4'd9;
   localparam logic [DIGIT_W-1:0] LIM_MT = 4'd5;
   localparam logic [DIGIT_W-1:0] LIM_MO = 4'd9;
   localparam logic [DIGIT_W-1:0] LIM_ST = 4'd5;
   localparam logic [DIGIT_W-1:0] LIM_SO = 4'd9;

   // Upper bound of the digit at position idx (5 = hours tens ... 0 = seconds ones).
   function automatic logic [DIGIT_W-1:0] digit_limit(input logic [2:0] idx,
                                                      input logic [DIGIT_W-1:0] lim_ht);
      case (idx)
         3'd5:    return lim_ht;
         3'd4:    return LIM_HO;
         3'd3:    return LIM_MT;
         3'd2:    return LIM_MO;
         3'd1:    return LIM_ST;
         default: return LIM_SO;
      endcase
   endfunction

   // One wrapping step of a digit within 0..lim; up selects increment.
   function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] cur,
                                                     input logic [DIGIT_W-1:0] lim,
                                                     input logic               up);
      if (up) begin
         return (cur >= lim) ? '0 : cur + 4'd1;
      end
      return (cur == '0 || cur > lim) ? lim : cur - 4'd1;
   endfunction

endpackage

// File: rtl/time_entry_btn_edge.sv
// Rising-edge detector for one push button. The history register resets
// to 1 so a button held through reset must be released before it acts.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic hist;

   // Remember the level sampled at the previous clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= 1'b1;
      end else begin
         hist <= btn;
      end
   end

   assign pulse = btn & ~hist;

endmodule

// File: rtl/time_entry.sv
// Front-panel editor that builds an HH:MM:SS BCD value digit by digit and
// hands it to the countdown timer with a set strobe of configurable length.
module time_entry
   import time_entry_pkg::*;
#(
   parameter int MAX_HT     = 9,
   parameter int SET_CYCLES = 1,
   parameter int ZERO_BLOCK = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_inc,
   input  logic               btn_dec,
   input  logic               btn_next,
   input  logic               btn_commit,
   input  logic               btn_clear,
   output logic [DIGIT_W-1:0] d5,
   output logic [DIGIT_W-1:0] d4,
   output logic [DIGIT_W-1:0] d3,
   output logic [DIGIT_W-1:0] d2,
   output logic [DIGIT_W-1:0] d1,
   output logic [DIGIT_W-1:0] d0,
   output logic               set,
   output logic [2:0]         cursor,
   output logic               edit_active,
   output logic               err
);

   localparam logic [DIGIT_W-1:0] LIM_HT    = DIGIT_W'(MAX_HT);
   localparam logic [3:0]         HOLD_LOAD = 4'(SET_CYCLES - 1);
   localparam logic               BLOCK_Z   = (ZERO_BLOCK != 0);

   logic inc_e, dec_e, next_e, commit_e, clear_e;
   logic [DIGIT_W-1:0] dig [6];
   logic [3:0]         hold_cnt;
   logic               all_zero;
   logic               step_e;
   state_t             state;

   btn_edge u_inc    (.clk(clk), .rst(rst), .btn(btn_inc),    .pulse(inc_e));
   btn_edge u_dec    (.clk(clk), .rst(rst), .btn(btn_dec),    .pulse(dec_e));
   btn_edge u_next   (.clk(clk), .rst(rst), .btn(btn_next),   .pulse(next_e));
   btn_edge u_commit (.clk(clk), .rst(rst), .btn(btn_commit), .pulse(commit_e));
   btn_edge u_clear  (.clk(clk), .rst(rst), .btn(btn_clear),  .pulse(clear_e));

   assign all_zero = (dig[5] == '0) && (dig[4] == '0) && (dig[3] == '0) &&
                     (dig[2] == '0) && (dig[1] == '0) && (dig[0] == '0);

   // inc and dec arriving together cancel each other.
   assign step_e = inc_e ^ dec_e;

   assign d5 = dig[5];
   assign d4 = dig[4];
   assign d3 = dig[3];
   assign d2 = dig[2];
   assign d1 = dig[1];
   assign d0 = dig[0];

   // Editor state machine with registered digits, cursor and strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         for (int i = 0; i < 6; i++) begin
            dig[i] <= '0;
         end
         cursor      <= 3'd5;
         set         <= 1'b0;
         edit_active <= 1'b0;
         err         <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE, EDIT: begin
               if (clear_e) begin
                  for (int i = 0; i < 6; i++) begin
                     dig[i] <= '0;
                  end
                  cursor <= 3'd5;
               end else if (commit_e) begin
                  if (BLOCK_Z && all_zero) begin
                     err <= 1'b1;
                  end else begin
                     state       <= COMMIT;
                     set         <= 1'b1;
                     edit_active <= 1'b0;
                     hold_cnt    <= HOLD_LOAD;
                  end
               end else if (state == IDLE) begin
                  if (next_e || step_e) begin
                     state       <= EDIT;
                     edit_active <= 1'b1;
                     cursor      <= 3'd5;
                  end
               end else if (next_e) begin
                  cursor <= (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
               end else if (step_e) begin
                  for (int i = 0; i < 6; i++) begin
                     if (cursor == 3'(i)) begin
                        dig[i] <= digit_step(dig[i], digit_limit(3'(i), LIM_HT), inc_e);
                     end
                  end
               end
            end
            COMMIT: begin
               if (hold_cnt == '0) begin
                  set    <= 1'b0;
                  state  <= IDLE;
                  cursor <= 3'd5;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_entry.sv
// Directed scoreboard bench for time_entry: unit A uses the default
// parameters, unit B uses MAX_HT=2 and SET_CYCLES=4.
module tb_time_entry;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] INC  = 5'b00001;
   localparam logic [4:0] DEC  = 5'b00010;
   localparam logic [4:0] NXT  = 5'b00100;
   localparam logic [4:0] CMT  = 5'b01000;
   localparam logic [4:0] CLR  = 5'b10000;

   typedef struct {
      string       tag;
      bit          unit;
      logic [23:0] digits;
      logic [2:0]  cursor;
      logic        edit;
      logic        set;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic [4:0] btn_a = '0;
   logic [4:0] btn_b = '0;

   logic [3:0] a_d5, a_d4, a_d3, a_d2, a_d1, a_d0;
   logic [3:0] b_d5, b_d4, b_d3, b_d2, b_d1, b_d0;
   logic       a_set, a_edit, a_err, b_set, b_edit, b_err;
   logic [2:0] a_cursor, b_cursor;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Free-running clock shared by both units.
   always #5 clk = ~clk;

   time_entry dut_a (
      .clk(clk), .rst(rst_a),
      .btn_inc(btn_a[0]), .btn_dec(btn_a[1]), .btn_next(btn_a[2]),
      .btn_commit(btn_a[3]), .btn_clear(btn_a[4]),
      .d5(a_d5), .d4(a_d4), .d3(a_d3), .d2(a_d2), .d1(a_d1), .d0(a_d0),
      .set(a_set), .cursor(a_cursor), .edit_active(a_edit), .err(a_err)
   );

   time_entry #(.MAX_HT(2), .SET_CYCLES(4), .ZERO_BLOCK(1)) dut_b (
      .clk(clk), .rst(rst_b),
      .btn_inc(btn_b[0]), .btn_dec(btn_b[1]), .btn_next(btn_b[2]),
      .btn_commit(btn_b[3]), .btn_clear(btn_b[4]),
      .d5(b_d5), .d4(b_d4), .d3(b_d3), .d2(b_d2), .d1(b_d1), .d0(b_d0),
      .set(b_set), .cursor(b_cursor), .edit_active(b_edit), .err(b_err)
   );

   // Queue the expected response and drive one cycle of stimulus.
   task automatic applyStimulus(input bit u, input logic r, input logic [4:0] m,
                                input string t, input logic [23:0] dg,
                                input logic [2:0] c, input logic ed,
                                input logic st, input logic er);
      exp_t e;
      e.tag = t; e.unit = u; e.digits = dg; e.cursor = c;
      e.edit = ed; e.set = st; e.err = er;
      sbq.push_back(e);
      @(negedge clk);
      if (u == 1'b0) begin
         rst_a = r;
         btn_a = m;
      end else begin
         rst_b = r;
         btn_b = m;
      end
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expectation and compare it against the unit's outputs.
   task automatic checkOutput();
      exp_t        e;
      logic [23:0] dg;
      logic [2:0]  c;
      logic        ed, st, er;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
         return;
      end
      e = sbq.pop_front();
      if (e.unit == 1'b0) begin
         dg = {a_d5, a_d4, a_d3, a_d2, a_d1, a_d0};
         c = a_cursor; ed = a_edit; st = a_set; er = a_err;
      end else begin
         dg = {b_d5, b_d4, b_d3, b_d2, b_d1, b_d0};
         c = b_cursor; ed = b_edit; st = b_set; er = b_err;
      end
      checks++;
      assert (dg === e.digits) else begin
         failures++;
         $error("[TB] FAIL %s.digits observed=%h expected=%h", e.tag, dg, e.digits);
      end
      checks++;
      assert (c === e.cursor) else begin
         failures++;
         $error("[TB] FAIL %s.cursor observed=%0d expected=%0d", e.tag, c, e.cursor);
      end
      checks++;
      assert (ed === e.edit) else begin
         failures++;
         $error("[TB] FAIL %s.edit_active observed=%b expected=%b", e.tag, ed, e.edit);
      end
      checks++;
      assert (st === e.set) else begin
         failures++;
         $error("[TB] FAIL %s.set observed=%b expected=%b", e.tag, st, e.set);
      end
      checks++;
      assert (er === e.err) else begin
         failures++;
         $error("[TB] FAIL %s.err observed=%b expected=%b", e.tag, er, e.err);
      end
   endtask

   task automatic step(input bit u, input logic r, input logic [4:0] m, input string t,
                       input logic [23:0] dg, input logic [2:0] c,
                       input logic ed, input logic st, input logic er);
      applyStimulus(u, r, m, t, dg, c, ed, st, er);
      checkOutput();
   endtask

   // Bound the run in case a wait never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence for both units.
   initial begin
      // ---------------- unit A: default parameters ----------------
      step(0, 1, NONE, "a_reset",      24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, NONE, "a_post_reset", 24'h000000, 3'd5, 0, 0, 0);

      // Build 01:30:00 and commit it.
      step(0, 0, NXT,  "a_enter_edit", 24'h000000, 3'd5, 1, 0, 0);
      step(0, 0, NONE, "a_rel",        24'h000000, 3'd5, 1, 0, 0);
      step(0, 0, NXT,  "a_next_c4",    24'h000000, 3'd4, 1, 0, 0);
      step(0, 0, NONE, "a_rel",        24'h000000, 3'd4, 1, 0, 0);
      step(0, 0, INC,  "a_inc_d4",     24'h010000, 3'd4, 1, 0, 0);
      step(0, 0, NONE, "a_rel",        24'h010000, 3'd4, 1, 0, 0);
      step(0, 0, NXT,  "a_next_c3",    24'h010000, 3'd3, 1, 0, 0);
      step(0, 0, NONE, "a_rel",        24'h010000, 3'd3, 1, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         step(0, 0, INC,  "a_inc_d3", 24'h010000 | (24'(k) << 12), 3'd3, 1, 0, 0);
         step(0, 0, NONE, "a_rel",    24'h010000 | (24'(k) << 12), 3'd3, 1, 0, 0);
      end
      step(0, 0, CMT,  "a_commit",      24'h013000, 3'd3, 0, 1, 0);
      step(0, 0, NONE, "a_commit_done", 24'h013000, 3'd5, 0, 0, 0);

      // Seconds-tens wrap in both directions.
      step(0, 0, NXT,  "a_reedit", 24'h013000, 3'd5, 1, 0, 0);
      step(0, 0, NONE, "a_rel",    24'h013000, 3'd5, 1, 0, 0);
      for (int k = 4; k >= 1; k--) begin
         step(0, 0, NXT,  "a_walk_cursor", 24'h013000, 3'(k), 1, 0, 0);
         step(0, 0, NONE, "a_rel",         24'h013000, 3'(k), 1, 0, 0);
      end
      for (int k = 1; k <= 6; k++) begin
         step(0, 0, INC,  "a_inc_d1", 24'h013000 | (24'(k % 6) << 4), 3'd1, 1, 0, 0);
         step(0, 0, NONE, "a_rel",    24'h013000 | (24'(k % 6) << 4), 3'd1, 1, 0, 0);
      end
      step(0, 0, DEC,  "a_dec_wrap_d1", 24'h013050, 3'd1, 1, 0, 0);
      step(0, 0, NONE, "a_rel",         24'h013050, 3'd1, 1, 0, 0);

      // Cursor wraps from 0 back to 5.
      step(0, 0, NXT,  "a_next_c0",     24'h013050, 3'd0, 1, 0, 0);
      step(0, 0, NONE, "a_rel",         24'h013050, 3'd0, 1, 0, 0);
      step(0, 0, NXT,  "a_cursor_wrap", 24'h013050, 3'd5, 1, 0, 0);
      step(0, 0, NONE, "a_rel",         24'h013050, 3'd5, 1, 0, 0);

      // d2 to 4, then simultaneous inc+dec and next+inc.
      for (int k = 4; k >= 2; k--) begin
         step(0, 0, NXT,  "a_walk_cursor", 24'h013050, 3'(k), 1, 0, 0);
         step(0, 0, NONE, "a_rel",         24'h013050, 3'(k), 1, 0, 0);
      end
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, INC,  "a_inc_d2", 24'h013050 | (24'(k) << 8), 3'd2, 1, 0, 0);
         step(0, 0, NONE, "a_rel",    24'h013050 | (24'(k) << 8), 3'd2, 1, 0, 0);
      end
      step(0, 0, INC | DEC, "a_inc_dec_cancel", 24'h013450, 3'd2, 1, 0, 0);
      step(0, 0, NONE,      "a_rel",            24'h013450, 3'd2, 1, 0, 0);
      step(0, 0, NXT | INC, "a_next_beats_inc", 24'h013450, 3'd1, 1, 0, 0);
      step(0, 0, NONE,      "a_rel",            24'h013450, 3'd1, 1, 0, 0);
      step(0, 0, CLR | NXT, "a_clear_edit",     24'h000000, 3'd5, 1, 0, 0);
      step(0, 0, NONE,      "a_rel",            24'h000000, 3'd5, 1, 0, 0);

      // All-zero commit is refused with a one-cycle err pulse.
      step(0, 0, CMT,  "a_zero_block",     24'h000000, 3'd5, 1, 0, 1);
      step(0, 0, NONE, "a_zero_block_end", 24'h000000, 3'd5, 1, 0, 0);

      // Build 00:00:05 then clear+commit together.
      for (int k = 4; k >= 0; k--) begin
         step(0, 0, NXT,  "a_walk_cursor", 24'h000000, 3'(k), 1, 0, 0);
         step(0, 0, NONE, "a_rel",         24'h000000, 3'(k), 1, 0, 0);
      end
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, INC,  "a_inc_d0", 24'(k), 3'd0, 1, 0, 0);
         step(0, 0, NONE, "a_rel",    24'(k), 3'd0, 1, 0, 0);
      end
      step(0, 0, CLR | CMT, "a_clear_beats_commit", 24'h000000, 3'd5, 1, 0, 0);
      step(0, 0, NONE,      "a_rel",                24'h000000, 3'd5, 1, 0, 0);

      // Commit from EDIT, then re-arm from IDLE.
      step(0, 0, INC,  "a_inc_d5",        24'h100000, 3'd5, 1, 0, 0);
      step(0, 0, NONE, "a_rel",           24'h100000, 3'd5, 1, 0, 0);
      step(0, 0, CMT,  "a_commit2",       24'h100000, 3'd5, 0, 1, 0);
      step(0, 0, NONE, "a_commit2_done",  24'h100000, 3'd5, 0, 0, 0);
      step(0, 0, CMT,  "a_idle_recommit", 24'h100000, 3'd5, 0, 1, 0);
      step(0, 0, NONE, "a_recommit_done", 24'h100000, 3'd5, 0, 0, 0);
      step(0, 0, CLR,  "a_idle_clear",    24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, NONE, "a_rel",           24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, CMT,  "a_idle_zero_block", 24'h000000, 3'd5, 0, 0, 1);
      step(0, 0, NONE, "a_rel",             24'h000000, 3'd5, 0, 0, 0);

      // Button held through reset does not fire until re-pressed.
      step(0, 1, INC,  "a_held_in_reset",  24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, INC,  "a_held_no_action", 24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, NONE, "a_held_release",   24'h000000, 3'd5, 0, 0, 0);
      step(0, 0, INC,  "a_held_repress",   24'h000000, 3'd5, 1, 0, 0);

      // ---------------- unit B: MAX_HT=2, SET_CYCLES=4 ----------------
      step(1, 1, NONE, "b_reset",      24'h000000, 3'd5, 0, 0, 0);
      step(1, 0, NONE, "b_post_reset", 24'h000000, 3'd5, 0, 0, 0);
      step(1, 0, NXT,  "b_enter_edit", 24'h000000, 3'd5, 1, 0, 0);
      step(1, 0, NONE, "b_rel",        24'h000000, 3'd5, 1, 0, 0);
      step(1, 0, INC,  "b_inc_ht1",    24'h100000, 3'd5, 1, 0, 0);
      step(1, 0, NONE, "b_rel",        24'h100000, 3'd5, 1, 0, 0);
      step(1, 0, INC,  "b_inc_ht2",    24'h200000, 3'd5, 1, 0, 0);
      step(1, 0, NONE, "b_rel",        24'h200000, 3'd5, 1, 0, 0);
      step(1, 0, INC,  "b_ht_wrap",    24'h000000, 3'd5, 1, 0, 0);
      step(1, 0, NONE, "b_rel",        24'h000000, 3'd5, 1, 0, 0);
      step(1, 0, DEC,  "b_ht_dec_wrap", 24'h200000, 3'd5, 1, 0, 0);
      step(1, 0, NONE, "b_rel",         24'h200000, 3'd5, 1, 0, 0);

      // Four-cycle set strobe; a press during it is discarded.
      step(1, 0, CMT,  "b_set1",          24'h200000, 3'd5, 0, 1, 0);
      step(1, 0, NONE, "b_set2",          24'h200000, 3'd5, 0, 1, 0);
      step(1, 0, INC,  "b_set3_ignored",  24'h200000, 3'd5, 0, 1, 0);
      step(1, 0, NONE, "b_set4",          24'h200000, 3'd5, 0, 1, 0);
      step(1, 0, NONE, "b_set_done",      24'h200000, 3'd5, 0, 0, 0);
      step(1, 0, NONE, "b_idle_hold",     24'h200000, 3'd5, 0, 0, 0);

      // Reset in the second set cycle aborts the load.
      step(1, 0, CMT,  "b_recommit",         24'h200000, 3'd5, 0, 1, 0);
      step(1, 0, NONE, "b_recommit_c2",      24'h200000, 3'd5, 0, 1, 0);
      step(1, 1, NONE, "b_reset_mid_commit", 24'h000000, 3'd5, 0, 0, 0);
      step(1, 0, NONE, "b_after_reset",      24'h000000, 3'd5, 0, 0, 0);
      step(1, 0, NONE, "b_no_late_set",      24'h000000, 3'd5, 0, 0, 0);

      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
